// File: rtl/pixel_array_pkg.sv
// rtl/pixel_array_pkg.sv - shared states, Gray helpers and index-width helper for pixel_array_ctrl
package pixel_array_pkg;

  // Frame sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ERASE   = 3'd1;
  localparam logic [2:0] ST_EXPOSE  = 3'd2;
  localparam logic [2:0] ST_CONVERT = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_STREAM  = 3'd5;

  // Index width for n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/adc_ramp_counter.sv
// rtl/adc_ramp_counter.sv - saturating ramp counter with optional Gray-coded output
module adc_ramp_counter
  import pixel_array_pkg::*;
#(
  parameter int DW   = 8,
  parameter int GRAY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic [DW-1:0] code,
  output logic          done
);

  logic [DW-1:0] bin;

  // Count one step per enabled cycle and hold at full scale so a frame never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
    end else if (clear) begin
      bin <= '0;
    end else if (enable && !done) begin
      bin <= bin + 1'b1;
    end
  end

  assign done = (bin == {DW{1'b1}});

  // Pixels latch this code, so Gray mode keeps adjacent codes one bit apart
  always_comb begin
    code = bin;
    if (GRAY != 0) code = DW'(bin2gray(32'(bin)));
  end

endmodule

// File: rtl/pixel_array_ctrl.sv
// rtl/pixel_array_ctrl.sv - frame sequencer and row/column readout engine for a pixel array
module pixel_array_ctrl
  import pixel_array_pkg::*;
#(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int DW           = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int READ_SETTLE  = 2,
  parameter int GRAY         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [15:0]               expose_time,
  output logic                      erase,
  output logic                      expose,
  output logic                      convert,
  output logic                      adc_drive,
  output logic [DW-1:0]             adc_code,
  output logic [ROWS-1:0]           read,
  input  logic [COLS*DW-1:0]        col_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [DW-1:0]             pix_data,
  output logic [idx_w(ROWS)-1:0]    pix_row,
  output logic [idx_w(COLS)-1:0]    pix_col,
  output logic                      pix_last,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  logic [2:0]         state;
  logic [15:0]        timer;
  logic [15:0]        exp_len;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic [COLS*DW-1:0] cap;
  logic               done_q;
  logic [DW-1:0]      ramp_code;
  logic               ramp_done;
  logic [DW-1:0]      sel;
  logic               hs;
  logic               last_col;
  logic               last_row;

  adc_ramp_counter #(.DW(DW), .GRAY(GRAY)) u_ramp (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ST_IDLE),
    .enable (state == ST_CONVERT),
    .code   (ramp_code),
    .done   (ramp_done)
  );

  assign hs       = pix_valid & pix_ready;
  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));

  // Phase sequencing, row/column walk and column capture; abort beats everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      exp_len <= '0;
      row     <= '0;
      col     <= '0;
      cap     <= '0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state   <= ST_IDLE;
      timer   <= '0;
      exp_len <= '0;
      row     <= '0;
      col     <= '0;
      cap     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ERASE;
            timer   <= 16'(ERASE_CYCLES - 1);
            exp_len <= (expose_time == 16'd0) ? 16'd1 : expose_time;
          end
        end
        ST_ERASE: begin
          if (timer == 16'd0) begin
            state <= ST_EXPOSE;
            timer <= exp_len - 16'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        ST_EXPOSE: begin
          if (timer == 16'd0) state <= ST_CONVERT;
          else                timer <= timer - 16'd1;
        end
        ST_CONVERT: begin
          if (ramp_done) begin
            state <= ST_SETTLE;
            row   <= '0;
            timer <= 16'(READ_SETTLE - 1);
          end
        end
        ST_SETTLE: begin
          if (timer == 16'd0) begin
            cap   <= col_data;
            col   <= '0;
            state <= ST_STREAM;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        ST_STREAM: begin
          if (hs) begin
            if (!last_col) begin
              col <= col + 1'b1;
            end else begin
              col <= '0;
              if (!last_row) begin
                row   <= row + 1'b1;
                timer <= 16'(READ_SETTLE - 1);
                state <= ST_SETTLE;
              end else begin
                row    <= '0;
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pick the captured column word currently being presented
  always_comb begin
    sel = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col == CW'(c)) sel = cap[c*DW +: DW];
    end
  end

  // Phase outputs decode straight from state so reset and abort clear them together
  always_comb begin
    erase      = (state == ST_ERASE);
    expose     = (state == ST_EXPOSE);
    convert    = (state == ST_CONVERT);
    adc_drive  = convert;
    adc_code   = convert ? ramp_code : '0;
    read       = (state == ST_SETTLE) ? (ROWS'(1) << row) : '0;
    pix_valid  = (state == ST_STREAM);
    pix_data   = '0;
    if (pix_valid) pix_data = (GRAY != 0) ? DW'(gray2bin(32'(sel))) : sel;
    pix_row    = pix_valid ? row : '0;
    pix_col    = pix_valid ? col : '0;
    pix_last   = pix_valid & last_row & last_col;
    busy       = (state != ST_IDLE);
    frame_done = done_q;
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb/tb_pixel_array_ctrl.sv - scoreboard bench for pixel_array_ctrl with a latching column model
module tb_pixel_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expose_time = 16'd0;
  logic        erase, expose, convert, adc_drive;
  logic [7:0]  adc_code;
  logic [1:0]  read;
  logic [15:0] col_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [7:0]  pix_data;
  logic [0:0]  pix_row, pix_col;
  logic        pix_last, busy, frame_done;

  pixel_array_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expose_time(expose_time),
    .erase(erase), .expose(expose), .convert(convert), .adc_drive(adc_drive),
    .adc_code(adc_code), .read(read), .col_data(col_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [7:0]  tgt [2][2];
  logic [7:0]  pix_mem [2][2];
  logic [10:0] exp_q [$];
  int n_erase, n_expose, n_conv, n_done, gray_bad, excl_bad, stall_bad, n_stalls;
  int start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  logic [7:0]  conv_codes [5];
  logic [7:0]  prev_code;
  logic        stall_prev = 1'b0;
  logic        abort_prev = 1'b0;
  logic [10:0] prev_pix;
  logic [10:0] got;
  logic [10:0] want;
  logic [7:0]  gray_exp [5];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [27:0] outs_now();
    return {erase, expose, convert, adc_drive, adc_code, read, pix_valid, pix_data,
            pix_row, pix_col, pix_last, busy, frame_done};
  endfunction

  // Column buses: the selected row drives the codes its pixels latched
  always_comb begin
    col_data = '0;
    for (int r = 0; r < 2; r++)
      if (read[r]) col_data = {pix_mem[r][1], pix_mem[r][0]};
  end

  // Ready generator: 0 = always ready, 1 = ~30% duty, 2 = never ready
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      1:       pix_ready = ($urandom_range(0, 9) < 3);
      2:       pix_ready = 1'b0;
      default: pix_ready = 1'b1;
    endcase
  end

  // Observe outputs mid-cycle: pixel latching, phase counts, stall rules, scoreboard
  always @(negedge clk) begin
    if (adc_drive)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          if (g2b(adc_code) == tgt[r][c]) pix_mem[r][c] = adc_code;
    if (erase)  n_erase++;
    if (expose) n_expose++;
    if (convert) begin
      if (n_conv < 5) conv_codes[n_conv] = adc_code;
      if (n_conv > 0 && $countones(adc_code ^ prev_code) != 1) gray_bad++;
      prev_code = adc_code;
      n_conv++;
    end
    if ($countones({erase, expose, convert, read}) > 1) excl_bad++;
    got = {pix_data, pix_row, pix_col, pix_last};
    if (stall_prev && !abort_prev && rst_n) begin
      n_stalls++;
      if (!pix_valid || got !== prev_pix) stall_bad++;
    end
    stall_prev = pix_valid && !pix_ready;
    abort_prev = abort;
    prev_pix   = got;
    if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        check("pix_unexpected", {53'd0, got}, 64'd0);
      end else begin
        want = exp_q.pop_front();
        check("pix", {53'd0, got}, {53'd0, want});
      end
      if (pix_last) last_hs_cyc = cyc;
    end
    if (frame_done) begin n_done++; done_cyc = cyc; end
  end

  task automatic set_tgt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    tgt[0][0] = a; tgt[0][1] = b; tgt[1][0] = c; tgt[1][1] = d;
  endtask

  task automatic push_expected();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        exp_q.push_back({tgt[r][c], r[0], c[0], (r == 1 && c == 1)});
  endtask

  // Returns one cycle after the accepting edge (the first ERASE cycle)
  task automatic start_frame(input logic [15:0] et);
    n_erase = 0; n_expose = 0; n_conv = 0; n_done = 0; gray_bad = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    expose_time = et;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (n_done == 0 && k < 2000) begin @(posedge clk); #1; k++; end
    check(tag, (n_done != 0), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!pix_valid && k < 600) begin @(posedge clk); #1; k++; end
    check(tag, pix_valid, 1'b1);
  endtask

  initial begin
    gray_exp = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06};
    set_tgt(8'h12, 8'h34, 8'h56, 8'h78);
    n_stalls = 0; stall_bad = 0; excl_bad = 0; n_done = 0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("reset_outputs", outs_now(), 28'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);

    // Frame 1: EXPOSE_TIME=10, always ready
    ready_mode = 0;
    push_expected();
    start_frame(16'd10);
    wait_done("f1_done_timeout");
    check("f1_erase_cycles", n_erase, 5);
    check("f1_expose_cycles", n_expose, 10);
    check("f1_convert_cycles", n_conv, 256);
    for (int i = 0; i < 5; i++) check("f1_gray_code", conv_codes[i], gray_exp[i]);
    check("f1_gray_adjacent", gray_bad, 0);
    // Cycle k after the accepting edge is observed with cyc == start_cyc + k - 1
    check("f1_latency", first_valid_cyc - start_cyc, 5 + 10 + 256 + 2 + 1 - 1);
    check("f1_done_after_last", done_cyc - last_hs_cyc, 1);
    check("f1_queue_empty", exp_q.size(), 0);
    check("f1_idle", busy, 1'b0);

    // Frame 2: same pixels, consumer stalls ~70% of cycles
    ready_mode = 1;
    push_expected();
    start_frame(16'd4);
    wait_done("f2_done_timeout");
    ready_mode = 0;
    check("f2_queue_empty", exp_q.size(), 0);
    check("f2_stalls_seen", (n_stalls > 0), 1'b1);

    // Frame 3: EXPOSE_TIME=0, boundary codes, START pulses in EXPOSE and STREAM
    set_tgt(8'h80, 8'h01, 8'hFF, 8'h00);
    push_expected();
    start_frame(16'd0);
    repeat (5) @(posedge clk); #1;
    check("f3_in_expose", expose, 1'b1);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_valid("f3_valid_timeout");
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_done("f3_done_timeout");
    repeat (3) @(posedge clk); #1;
    check("f3_expose_cycles", n_expose, 1);
    check("f3_erase_cycles", n_erase, 5);
    check("f3_gray_latch", pix_mem[0][0], 8'hC0);
    check("f3_start_ignored", busy, 1'b0);
    check("f3_queue_empty", exp_q.size(), 0);

    // Abort during CONVERT
    start_frame(16'd10);
    repeat (5 + 10 + 100 - 1) @(posedge clk); #1;
    check("ab1_in_convert", convert, 1'b1);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    check("ab1_outputs", outs_now(), 28'd0);
    repeat (10) @(posedge clk); #1;
    check("ab1_no_done", n_done, 0);

    // Abort during STREAM with a pixel pending
    ready_mode = 2;
    start_frame(16'd3);
    wait_valid("ab2_valid_timeout");
    repeat (2) @(posedge clk); #1;
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    check("ab2_outputs", outs_now(), 28'd0);
    repeat (10) @(posedge clk); #1;
    check("ab2_no_done", n_done, 0);
    ready_mode = 0;

    // Fresh full frame after aborts
    set_tgt(8'h12, 8'h34, 8'h56, 8'h78);
    push_expected();
    start_frame(16'd6);
    wait_done("f4_done_timeout");
    check("f4_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of ROW_SETTLE
    start_frame(16'd2);
    begin
      int k = 0;
      while (read == 2'b00 && k < 600) begin @(posedge clk); #1; k++; end
    end
    check("rst_in_settle", (read != 2'b00), 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_read_async", read, 2'b00);
    check("rst_outputs_async", outs_now(), 28'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("rst_idle", busy, 1'b0);
    check("rst_no_done", n_done, 0);

    check("stall_stable", stall_bad, 0);
    check("phase_exclusive", excl_bad, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
